// File: rtl/imem_dump_uart.sv
// IMEM readback over UART: each byte is sent as two uppercase ASCII hex characters (8N1).
// Define IMEM_DUMP_CRLF_EN to append CR LF after every byte (one line per address).
module imem_dump_uart #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] last_addr,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND_HI,
    SEND_LO,
`ifdef IMEM_DUMP_CRLF_EN
    SEP,
`endif
    NEXT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  state_t          state;
  tx_state_t       tx_state;
  logic [7:0]      last_q;
  logic [7:0]      byte_q;
  logic            load;
  logic [7:0]      load_char;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   baud_cnt;
  logic            tx_ready;
`ifdef IMEM_DUMP_CRLF_EN
  logic            sep_lf;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // A load issued last cycle has not yet left TX_IDLE, so it must block the next one.
  assign tx_ready = (tx_state == TX_IDLE) && !load;

  // Each SEND state waits for the serializer before loading, so the next
  // byte is fetched while the low nibble is still on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      imem_addr <= '0;
      last_q    <= '0;
      byte_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load      <= 1'b0;
      load_char <= '0;
`ifdef IMEM_DUMP_CRLF_EN
      sep_lf    <= 1'b0;
`endif
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            last_q    <= last_addr;
            imem_addr <= '0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          byte_q <= imem_data;
          state  <= SEND_HI;
        end
        SEND_HI: begin
          if (tx_ready) begin
            load      <= 1'b1;
            load_char <= hex_char(byte_q[7:4]);
            state     <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ready) begin
            load      <= 1'b1;
            load_char <= hex_char(byte_q[3:0]);
`ifdef IMEM_DUMP_CRLF_EN
            state     <= SEP;
`else
            state     <= NEXT;
`endif
          end
        end
`ifdef IMEM_DUMP_CRLF_EN
        SEP: begin
          if (tx_ready) begin
            load <= 1'b1;
            if (!sep_lf) begin
              load_char <= 8'h0D;
              sep_lf    <= 1'b1;
            end else begin
              load_char <= 8'h0A;
              sep_lf    <= 1'b0;
              state     <= NEXT;
            end
          end
        end
`endif
        NEXT: begin
          if (imem_addr == last_q) begin
            if (tx_ready) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end else begin
            imem_addr <= imem_addr + 8'd1;
            state     <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (load) begin
            shreg    <= load_char;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            tx_state <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx_state <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dump_uart.sv
// Directed bench for imem_dump_uart at 4 clocks per bit with a UART receiver and IMEM model.
module tb_imem_dump_uart;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] rxq [$];
  int         stq [$];
  logic [7:0] alog [$];
  logic [7:0] exp_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int frame_err = 0;

  imem_dump_uart #(.CLK_FREQ(4), .BAUD(1)) dut (
    .clk(clk), .reset(reset), .start(start), .last_addr(last_addr),
    .imem_addr(imem_addr), .imem_data(imem_data), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && (alog.size() == 0 || imem_addr != alog[alog.size()-1]))
      alog.push_back(imem_addr);
  end

  initial begin : rx_mon
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(b);
        stq.push_back(st);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] la);
    last_addr = la;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_sep();
`ifdef IMEM_DUMP_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic clear_logs();
    rxq.delete();
    stq.delete();
    alog.delete();
    exp_q.delete();
    frame_err = 0;
  endtask

  task automatic cmp_stream(input string tag);
    int m;
    m = 0;
    check({tag, "_len"}, rxq.size(), exp_q.size());
    for (int i = 0; i < rxq.size() && i < exp_q.size(); i++)
      if (rxq[i] !== exp_q[i]) m++;
    check({tag, "_chars"}, m, 0);
    check({tag, "_framing"}, frame_err, 0);
  endtask

  initial begin
    bit ok;
    int n0, k, dl, gmax, gmin;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset values
    tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", imem_addr, 0);
    reset = 1'b1;
    repeat (3) tick();

    // Case 1: single byte 0x3A
    mem[0] = 8'h3A;
    clear_logs();
    exp_q = '{8'h33, 8'h41};
    push_sep();
    n0 = done_cnt;
    pulse_start(8'h00);
    check("c1_busy_after_start", busy, 1);
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (tx === 1'b0) begin
        k = i;
        break;
      end
    end
    check("c1_start_bit_latency_ok", (k >= 1 && k <= 5) ? 1 : 0, 1);
    wait_done(400, ok);
    check("c1_done_seen", ok, 1);
    check("c1_busy_at_done", busy, 0);
    dl = cyc - stq[stq.size()-1];
    check("c1_done_after_stop_ok", (dl >= 40 && dl <= 42) ? 1 : 0, 1);
    repeat (20) tick();
    cmp_stream("c1");
    check("c1_done_count", done_cnt - n0, 1);
    check("c1_addr", imem_addr, 0);
    check("c1_addr_reads", alog.size(), 1);

    // Case 2: three bytes "00FF9B"
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h9B;
    clear_logs();
    exp_q = '{8'h30, 8'h30};
    push_sep();
    exp_q.push_back(8'h46); exp_q.push_back(8'h46);
    push_sep();
    exp_q.push_back(8'h39); exp_q.push_back(8'h42);
    push_sep();
    n0 = done_cnt;
    pulse_start(8'h02);
    wait_done(1200, ok);
    check("c2_done_seen", ok, 1);
    repeat (20) tick();
    cmp_stream("c2");
    check("c2_done_count", done_cnt - n0, 1);
    check("c2_addr_hold", imem_addr, 2);
    check("c2_addr_reads", alog.size(), 3);
    check("c2_addr_seq", (alog.size() == 3 && alog[0] == 8'h00 && alog[1] == 8'h01 && alog[2] == 8'h02) ? 1 : 0, 1);
    gmax = 0; gmin = 1000;
    for (int i = 0; i + 1 < stq.size(); i++) begin
      if (stq[i+1] - stq[i] > gmax) gmax = stq[i+1] - stq[i];
      if (stq[i+1] - stq[i] < gmin) gmin = stq[i+1] - stq[i];
    end
    check("c2_char_spacing_ok", (gmin >= 40 && gmax <= 43) ? 1 : 0, 1);

    // Case 3: start and last_addr changes mid-dump are ignored
    clear_logs();
    exp_q = '{8'h30, 8'h30};
    push_sep();
    exp_q.push_back(8'h46); exp_q.push_back(8'h46);
    push_sep();
    exp_q.push_back(8'h39); exp_q.push_back(8'h42);
    push_sep();
    n0 = done_cnt;
    pulse_start(8'h02);
    repeat (60) tick();
    pulse_start(8'h00);
    check("c3_busy_mid", busy, 1);
    wait_done(1200, ok);
    check("c3_done_seen", ok, 1);
    repeat (60) tick();
    cmp_stream("c3");
    check("c3_done_count", done_cnt - n0, 1);
    check("c3_addr_reads", alog.size(), 3);

    // Case 4: reset during the data bits of the second character
    mem[0] = 8'h3A; mem[1] = 8'h7E;
    clear_logs();
    pulse_start(8'h00);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rxq.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("c4_first_char_seen", ok, 1);
    repeat (12) tick();
    reset = 1'b0;
    #1;
    check("c4_rst_tx", tx, 1);
    check("c4_rst_busy", busy, 0);
    check("c4_rst_done", done, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (60) tick();
    clear_logs();
    exp_q = '{8'h33, 8'h41};
    push_sep();
    exp_q.push_back(8'h37); exp_q.push_back(8'h45);
    push_sep();
    n0 = done_cnt;
    pulse_start(8'h01);
    check("c4_restart_addr", imem_addr, 0);
    wait_done(1000, ok);
    check("c4_done_seen", ok, 1);
    repeat (20) tick();
    cmp_stream("c4");
    check("c4_done_count", done_cnt - n0, 1);
    check("c4_first_read", (alog.size() > 0 && alog[0] == 8'h00) ? 1 : 0, 1);

    // Case 5: full 256-byte dump, IMEM[i] = i
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      logic [3:0] hi, lo;
      v = 8'(i);
      hi = v[7:4];
      lo = v[3:0];
      exp_q.push_back(hi < 4'd10 ? 8'h30 + 8'(hi) : 8'h41 + 8'(hi) - 8'd10);
      exp_q.push_back(lo < 4'd10 ? 8'h30 + 8'(lo) : 8'h41 + 8'(lo) - 8'd10);
      push_sep();
    end
    n0 = done_cnt;
    pulse_start(8'hFF);
    wait_done(60000, ok);
    check("c5_done_seen", ok, 1);
    repeat (20) tick();
    cmp_stream("c5");
`ifndef IMEM_DUMP_CRLF_EN
    check("c5_tail", (rxq.size() >= 2 && rxq[rxq.size()-2] == 8'h46 && rxq[rxq.size()-1] == 8'h46) ? 1 : 0, 1);
`endif
    check("c5_addr_final", imem_addr, 8'hFF);
    check("c5_addr_reads", alog.size(), 256);
    check("c5_done_count", done_cnt - n0, 1);

`ifdef IMEM_DUMP_CRLF_EN
    // Case 6: CRLF line for IMEM[0] = 0x5C
    mem[0] = 8'h5C;
    clear_logs();
    exp_q = '{8'h35, 8'h43, 8'h0D, 8'h0A};
    n0 = done_cnt;
    pulse_start(8'h00);
    wait_done(600, ok);
    check("c6_done_seen", ok, 1);
    repeat (20) tick();
    cmp_stream("c6");
    check("c6_done_count", done_cnt - n0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
